// File: rtl/fmad_ctrl_pkg.sv
// Shared FPU constants: unit latencies, tag width and side-data sizing.
// Latencies are counted in clken=1 cycles of the owning unit.
package fmad_ctrl_pkg;

  localparam int FPU_WORD_W   = 32;
  localparam int FPU_MUL_LAT  = 3;
  localparam int FPU_ADD_LAT  = 7;
  localparam int FPU_DIV_LAT  = 12;
  localparam int FPU_SQRT_LAT = 16;
  localparam int FPU_TAG_W    = 5;

  // Mul-side record: {valid, c, is_sub, is_neg, tag}
  function automatic int mul_side_w(input int tag_w);
    return 1 + FPU_WORD_W + 2 + tag_w;
  endfunction

endpackage

// File: rtl/fmad_ctrl_if.sv
// Bundle of the issue, fp_mul, fmad_add and writeback signals around fmad_ctrl.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid and its payload hold until that edge, ready may change freely.
interface fmad_ctrl_if
  import fmad_ctrl_pkg::*;
#(
  parameter int TAG_W = FPU_TAG_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [FPU_WORD_W-1:0] in_a;
  logic [FPU_WORD_W-1:0] in_b;
  logic [FPU_WORD_W-1:0] in_c;
  logic                  in_is_neg;
  logic                  in_is_sub;
  logic [TAG_W-1:0]      in_tag;

  logic                  mul_clken;
  logic [FPU_WORD_W-1:0] mul_ope1;
  logic [FPU_WORD_W-1:0] mul_ope2;
  logic [FPU_WORD_W-1:0] mul_q;

  logic                  add_clken;
  logic [FPU_WORD_W-1:0] add_ope1;
  logic [FPU_WORD_W-1:0] add_ope2;
  logic                  add_is_sub;
  logic                  add_is_neg;
  logic [FPU_WORD_W-1:0] add_q;

  logic                  out_valid;
  logic                  out_ready;
  logic [FPU_WORD_W-1:0] out_q;
  logic [TAG_W-1:0]      out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_is_neg, in_is_sub, in_tag,
    input  mul_q, add_q, out_ready,
    output in_ready, mul_clken, mul_ope1, mul_ope2,
    output add_clken, add_ope1, add_ope2, add_is_sub, add_is_neg,
    output out_valid, out_q, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_is_neg, in_is_sub, in_tag,
    output mul_q, add_q, out_ready,
    input  in_ready, mul_clken, mul_ope1, mul_ope2,
    input  add_clken, add_ope1, add_ope2, add_is_sub, add_is_neg,
    input  out_valid, out_q, out_tag
  );

endinterface

// File: rtl/fmad_ctrl_tag_pipe.sv
// Enable-gated shift register of DEPTH stages; carries side data alongside
// an external pipeline that freezes on the same enable.
module fpu_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/fmad_ctrl.sv
// Fused multiply-add control: sequences external fp_mul and fmad_add, carries
// the per-op side data through matching delay lines and registers the result.
module fmad_ctrl
  import fmad_ctrl_pkg::*;
#(
  parameter int MUL_LAT = FPU_MUL_LAT,
  parameter int ADD_LAT = FPU_ADD_LAT,
  parameter int TAG_W   = FPU_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  fmad_ctrl_if.slave  io_bus
);

  localparam int MSIDE_W = mul_side_w(TAG_W);
  localparam int ASIDE_W = 1 + TAG_W;

  logic                  w_stall;
  logic                  w_advance;
  logic [MSIDE_W-1:0]    w_mside_d;
  logic [MSIDE_W-1:0]    w_mside_q;
  logic [ASIDE_W-1:0]    w_aside_d;
  logic [ASIDE_W-1:0]    w_aside_q;

  logic                  r_out_valid;
  logic [FPU_WORD_W-1:0] r_out_q;
  logic [TAG_W-1:0]      r_out_tag;

  // Reset forces advance so the issue port reads ready during rst.
  assign w_stall   = r_out_valid & ~io_bus.out_ready & ~rst;
  assign w_advance = ~w_stall;

  assign io_bus.in_ready  = w_advance;
  assign io_bus.mul_clken = w_advance;
  assign io_bus.add_clken = w_advance;
  assign io_bus.mul_ope1  = io_bus.in_a;
  assign io_bus.mul_ope2  = io_bus.in_b;

  assign w_mside_d = {io_bus.in_valid, io_bus.in_c, io_bus.in_is_sub,
                      io_bus.in_is_neg, io_bus.in_tag};

  fpu_tag_pipe #(.DEPTH(MUL_LAT), .W(MSIDE_W)) u_mul_side (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_advance),
    .i_d  (w_mside_d),
    .o_q  (w_mside_q)
  );

  assign io_bus.add_ope1   = io_bus.mul_q;
  assign io_bus.add_ope2   = w_mside_q[MSIDE_W-2 -: FPU_WORD_W];
  assign io_bus.add_is_sub = w_mside_q[TAG_W+1];
  assign io_bus.add_is_neg = w_mside_q[TAG_W];

  assign w_aside_d = {w_mside_q[MSIDE_W-1], w_mside_q[TAG_W-1:0]};

  fpu_tag_pipe #(.DEPTH(ADD_LAT), .W(ASIDE_W)) u_add_side (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_advance),
    .i_d  (w_aside_d),
    .o_q  (w_aside_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r_out_valid <= w_aside_q[ASIDE_W-1];
      r_out_q     <= io_bus.add_q;
      r_out_tag   <= w_aside_q[TAG_W-1:0];
    end
  end

  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_q     = r_out_q;
  assign io_bus.out_tag   = r_out_tag;

endmodule
